uart_imem_loader: RTL and testbench

UART_IMEM_LOADER -- requirements
Module: uart_imem_loader

---
 rtl/riscv_loader_pkg.sv | 31 +++
 rtl/uart_rx_byte.sv | 105 ++++++++++
 rtl/uart_imem_loader.sv | 137 +++++++++++++
 tb/tb_uart_imem_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader.
//   SYNC_BYTE     : byte that opens (or restarts) a load frame
//   loader_state_t: loader FSM state encodings
//   rx_state_t    : UART byte receiver state encodings
//   len_in_range  : accepts a word count of 1 .. 2^addr_w
package riscv_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    function automatic logic len_in_range(input logic [15:0] n, input int unsigned addr_w);
        return (n != 16'd0) && (32'(n) <= (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver, LSB first, idle-high line.
//   clk, reset  : clock and asynchronous active-low reset
//   rx          : raw serial input (synchronized internally)
//   byte_valid  : one-cycle pulse, byte_data holds a good byte
//   byte_data   : received byte
//   frame_err   : one-cycle pulse, stop bit was 0 and the byte is dropped
module uart_rx_byte
    import riscv_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    logic            meta_q, sync_q, prev_q;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    // The synchronizer and edge history reset to 0, so a start edge is only
    // recognised once the line has been seen high after reset; a frame that
    // was in flight when reset was released is therefore ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            meta_q  <= rx;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync_q) state_d = RX_START;
            end
            RX_START: begin
                // Mid-start recheck: a line already back high was a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync_q;
                    ferr_d  = !sync_q;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Loads a program image received over UART into instruction memory and
// holds the core in reset until a complete, checksum-verified image is in.
// Frame: A5, N (16-bit LE word count), 4N data bytes (LE words), XOR checksum.
//   clk, reset  : clock and asynchronous active-low reset
//   uart_rx     : serial input, 8N1, idle high
//   imem_we     : one-cycle write strobe
//   imem_addr   : word address of imem_wdata
//   imem_wdata  : assembled 32-bit instruction word
//   core_hold   : 1 keeps the processor in reset (all states except DONE)
//   load_done   : image loaded and verified (sticky until reset)
//   load_error  : framing/length/checksum failure (cleared by next sync byte)
module uart_imem_loader
    import riscv_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_error
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (uart_rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    loader_state_t     state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic              we_q, we_d;
    logic              last_word;
    logic              is_sync;

    assign last_word = (16'(addr_q) == len_q - 16'd1);
    assign is_sync   = byte_valid && (byte_data == SYNC_BYTE);

    // State register together with the datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SYNC;
            len_q   <= '0;
            csum_q  <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            bcnt_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            csum_q  <= csum_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            bcnt_q  <= bcnt_d;
            we_q    <= we_d;
        end
    end

    // Next-state logic. A framing error aborts any load in progress.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:   if (is_sync) state_d = LEN_LO;
            LEN_LO: if (frame_err) state_d = ERROR;
                    else if (byte_valid) state_d = LEN_HI;
            LEN_HI: if (frame_err) state_d = ERROR;
                    else if (byte_valid)
                        state_d = len_in_range({byte_data, len_q[7:0]}, ADDR_W) ? DATA : ERROR;
            // Leave DATA only after the strobe cycle of the last word.
            DATA:   if (frame_err) state_d = ERROR;
                    else if (we_q && last_word) state_d = CSUM;
            CSUM:   if (frame_err) state_d = ERROR;
                    else if (byte_valid) state_d = (byte_data == csum_q) ? DONE : ERROR;
            DONE:   state_d = DONE;
            ERROR:  if (is_sync) state_d = LEN_LO;
            default: state_d = SYNC;
        endcase
    end

    // Datapath next-state: length capture, word assembly, checksum, address.
    always_comb begin
        len_d  = len_q;
        csum_d = csum_q;
        addr_d = addr_q;
        word_d = word_q;
        bcnt_d = bcnt_q;
        we_d   = 1'b0;
        if (byte_valid) begin
            case (state_q)
                SYNC, ERROR: if (is_sync) begin
                    csum_d = '0;
                    addr_d = '0;
                    bcnt_d = '0;
                end
                LEN_LO: len_d[7:0]  = byte_data;
                LEN_HI: len_d[15:8] = byte_data;
                DATA: begin
                    word_d = {byte_data, word_q[31:8]};
                    csum_d = csum_q ^ byte_data;
                    bcnt_d = bcnt_q + 2'd1;
                    we_d   = (bcnt_q == 2'd3);
                end
                default: ;
            endcase
        end
        // The last word keeps its address, so a full 2^ADDR_W image never wraps.
        if (we_q && !last_word) addr_d = addr_q + ADDR_W'(1);
    end

    // Outputs.
    always_comb begin
        imem_we    = we_q;
        imem_addr  = addr_q;
        imem_wdata = word_q;
        core_hold  = (state_q != DONE);
        load_done  = (state_q == DONE);
        load_error = (state_q == ERROR);
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
module tb_uart_imem_loader;
    import riscv_loader_pkg::*;

    localparam int CPB = 16;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          uart_rx = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_hold;
    logic          load_done;
    logic          load_error;

    int vectors = 0;
    int errors  = 0;

    // Write log filled by the monitor below.
    int          we_cnt = 0;
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];

    uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            we_cnt = we_cnt + 1;
            wr_addr.push_back(32'(imem_addr));
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(posedge clk);
        uart_rx = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    // Two-word image: 0x00000013, 0x001000B3; XOR of the eight data bytes is 0xB0.
    task automatic send_frame_2w();
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'hB3); send(8'h00); send(8'h10); send(8'h00);
        send(8'hB0);
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        check({tag, "_we"},    32'(imem_we),    32'd0);
        check({tag, "_addr"},  32'(imem_addr),  32'd0);
        check({tag, "_wdata"}, imem_wdata,      32'd0);
        check({tag, "_hold"},  32'(core_hold),  32'd1);
        check({tag, "_done"},  32'(load_done),  32'd0);
        check({tag, "_err"},   32'(load_error), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    int base;

    initial begin
        // Reset state.
        uart_rx = 1'b1;
        reset   = 1'b0;
        repeat (3) @(posedge clk);
        check_reset_vals("por");
        reset = 1'b1;
        repeat (8) @(posedge clk);

        // 3-cycle glitch, then 0x55 (discarded) and sync byte.
        uart_rx = 1'b0;
        repeat (3) @(posedge clk);
        uart_rx = 1'b1;
        repeat (40) @(posedge clk);
        send(8'h55);
        @(negedge clk);
        check("glitch_55_state", 32'(dut.state_q), 32'(SYNC));
        send(8'hA5);
        @(negedge clk);
        check("sync_to_len_lo", 32'(dut.state_q), 32'(LEN_LO));

        // Rest of the good two-word frame.
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'hB3); send(8'h00); send(8'h10); send(8'h00);
        @(negedge clk);
        check("good_we_count", 32'(we_cnt), 32'd2);
        check("good_addr0", wr_addr[0], 32'd0);
        check("good_data0", wr_data[0], 32'h0000_0013);
        check("good_addr1", wr_addr[1], 32'd1);
        check("good_data1", wr_data[1], 32'h0010_00B3);
        check("pre_csum_hold", 32'(core_hold), 32'd1);
        check("pre_csum_done", 32'(load_done), 32'd0);
        send(8'hB0);
        @(negedge clk);
        check("good_done", 32'(load_done),  32'd1);
        check("good_hold", 32'(core_hold),  32'd0);
        check("good_err",  32'(load_error), 32'd0);

        // DONE ignores all further input.
        send(8'hA5); send(8'h01); send(8'h00);
        @(negedge clk);
        check("done_sticky", 32'(load_done), 32'd1);
        check("done_no_we",  32'(we_cnt),    32'd2);

        // Bad checksum, then a correct frame recovers.
        do_reset();
        check_reset_vals("rst2");
        base = we_cnt;
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h00);
        @(negedge clk);
        check("badsum_err",  32'(load_error), 32'd1);
        check("badsum_hold", 32'(core_hold),  32'd1);
        check("badsum_done", 32'(load_done),  32'd0);
        check("badsum_word_kept", 32'(we_cnt - base), 32'd1);
        send(8'hA5);
        @(negedge clk);
        check("resync_clears_err", 32'(load_error), 32'd0);
        send(8'h01); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h13);
        @(negedge clk);
        check("recover_done", 32'(load_done),  32'd1);
        check("recover_err",  32'(load_error), 32'd0);

        // Length N=17 exceeds 16 words.
        do_reset();
        base = we_cnt;
        send(8'hA5); send(8'h11); send(8'h00);
        @(negedge clk);
        check("len17_err", 32'(load_error), 32'd1);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        @(negedge clk);
        check("len17_no_we", 32'(we_cnt - base), 32'd0);

        // Length N=0 is rejected; N=16 is accepted.
        do_reset();
        send(8'hA5); send(8'h00); send(8'h00);
        @(negedge clk);
        check("len0_err", 32'(load_error), 32'd1);
        send(8'hA5); send(8'h10); send(8'h00);
        @(negedge clk);
        check("len16_ok", 32'(dut.state_q), 32'(DATA));

        // Framing error on the 2nd data byte.
        do_reset();
        base = we_cnt;
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h13);
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        check("frame_err_state", 32'(load_error), 32'd1);
        send(8'h00); send(8'h00);
        @(negedge clk);
        check("frame_err_no_we", 32'(we_cnt - base), 32'd0);

        // Reset in the middle of the 3rd data byte, then a full reload.
        do_reset();
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h13); send(8'h00);
        uart_rx = 1'b0;
        repeat (CPB + 3 * CPB) @(posedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        check_reset_vals("midbyte");
        reset = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        base = we_cnt;
        send_frame_2w();
        @(negedge clk);
        check("reload_we_count", 32'(we_cnt - base), 32'd2);
        check("reload_addr0", wr_addr[base],     32'd0);
        check("reload_data0", wr_data[base],     32'h0000_0013);
        check("reload_addr1", wr_addr[base + 1], 32'd1);
        check("reload_data1", wr_data[base + 1], 32'h0010_00B3);
        check("reload_done",  32'(load_done),    32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
